q_sys_cpu_debug_slave_sync: RTL

//  Parametrised successor to the Nios II debug-slave tck/sysclk split. Oversamples the virtual-JTAG

---
 rtl/q_sys_cpu_debug_slave_sync.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/q_sys_cpu_debug_slave_sync.sv
// q_sys_cpu_debug_slave_sync
// Virtual-JTAG debug slave running entirely on the system clock. The asynchronous
// dbg_* strobes are oversampled through SYNC_N-deep synchronisers. tck edges drive a
// DR_W-bit capture/shift register. Each update-DR becomes a one-hot action or
// no-action command, which is held until the consumer acknowledges it.
// Optional feature macro: DBG_PARITY_EN
// When DBG_PARITY_EN is defined, bit DR_W-2 of the word is odd parity over bits DR_W-3..0.
// A bad word is rejected and reported on par_err / par_err_cnt.
module q_sys_cpu_debug_slave_sync #(
    parameter int IR_W   = 2,
    parameter int DR_W   = 38,
    parameter int SYNC_N = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         dbg_tck,
    input  logic                         dbg_tdi,
    input  logic [IR_W-1:0]              dbg_ir_in,
    input  logic                         dbg_cdr,
    input  logic                         dbg_sdr,
    input  logic                         dbg_udr,
    output logic                         dbg_tdo,
    input  logic [(1<<IR_W)*DR_W-1:0]    cap_data,
    output logic [DR_W-1:0]              jdo,
    output logic [(1<<IR_W)-1:0]         take_action,
    output logic [(1<<IR_W)-1:0]         take_no_action,
    input  logic                         act_ack,
    output logic                         overrun,
`ifdef DBG_PARITY_EN
    output logic                         par_err,
    output logic [7:0]                   par_err_cnt,
`endif
    output logic                         busy
);

    localparam int NCH = 1 << IR_W;
    localparam int VW  = IR_W + 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    logic [SYNC_N-1:0][VW-1:0] sync_q, sync_d;
    logic [VW-1:0]             dbg_vec_s;
    logic                      tck_s, tdi_s, cdr_s, sdr_s, udr_s;
    logic [IR_W-1:0]           ir_s;
    logic                      tck_rise_s, tck_fall_s, udr_rise_s;
    logic                      tck_prev_q, tck_prev_d;
    logic                      udr_prev_q, udr_prev_d;
    logic                      upd_evt_q, upd_evt_d;
    logic [IR_W-1:0]           upd_ir_q, upd_ir_d;
    logic [DR_W-1:0]           sr_q, sr_d, cap_sel_s;
    logic                      tdo_q, tdo_d;
    state_t                    state_q, state_d;
    logic [DR_W-1:0]           jdo_q, jdo_d;
    logic [NCH-1:0]            ta_q, ta_d, tna_q, tna_d, onehot_s;
    logic                      ovr_q, ovr_d;
    logic                      busy_q, busy_d;
    logic                      good_upd_s;

`ifdef DBG_PARITY_EN
    logic                      par_err_q, par_err_d;
    logic [7:0]                par_cnt_q, par_cnt_d;

    // Odd parity holds when bits DR_W-2..0 contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [DR_W-1:0] w);
        return ^w[DR_W-2:0];
    endfunction

    assign good_upd_s  = upd_evt_q & odd_parity_ok(sr_q);
    assign par_err     = par_err_q;
    assign par_err_cnt = par_cnt_q;
`else
    assign good_upd_s  = upd_evt_q;
`endif

    assign dbg_vec_s = {dbg_tck, dbg_tdi, dbg_ir_in, dbg_cdr, dbg_sdr, dbg_udr};
    assign {tck_s, tdi_s, ir_s, cdr_s, sdr_s, udr_s} = sync_q[SYNC_N-1];
    assign tck_rise_s = tck_s & ~tck_prev_q;
    assign tck_fall_s = ~tck_s & tck_prev_q;
    assign udr_rise_s = udr_s & ~udr_prev_q;
    assign cap_sel_s  = cap_data[int'(ir_s)*DR_W +: DR_W];
    assign onehot_s   = {{(NCH-1){1'b0}}, 1'b1} << upd_ir_q;

    assign dbg_tdo        = tdo_q;
    assign jdo            = jdo_q;
    assign take_action    = ta_q;
    assign take_no_action = tna_q;
    assign overrun        = ovr_q;
    assign busy           = busy_q;

    // Front end: synchronisers, edge detection, and the capture/shift register with TDO
    always_comb begin
        sync_d     = {sync_q[SYNC_N-2:0], dbg_vec_s};
        tck_prev_d = tck_s;
        udr_prev_d = udr_s;
        upd_evt_d  = udr_rise_s;
        if (udr_rise_s) begin
            upd_ir_d = ir_s;
        end else begin
            upd_ir_d = upd_ir_q;
        end
        if (tck_rise_s && cdr_s) begin
            sr_d = cap_sel_s;
        end else if (tck_rise_s && sdr_s) begin
            sr_d = {tdi_s, sr_q[DR_W-1:1]};
        end else begin
            sr_d = sr_q;
        end
        if (tck_fall_s) begin
            tdo_d = sr_q[0];
        end else begin
            tdo_d = tdo_q;
        end
    end

    // Command FSM: load on update, retire on ack, and flag updates that collide with a pending command
    always_comb begin
        state_d = state_q;
        jdo_d   = jdo_q;
        ta_d    = ta_q;
        tna_d   = tna_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (good_upd_s) begin
                    state_d = ST_CMD;
                    jdo_d   = sr_q;
                    ta_d    = sr_q[DR_W-1] ? onehot_s : {NCH{1'b0}};
                    tna_d   = sr_q[DR_W-1] ? {NCH{1'b0}} : onehot_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (act_ack && good_upd_s) begin
                    jdo_d = sr_q;
                    ta_d  = sr_q[DR_W-1] ? onehot_s : {NCH{1'b0}};
                    tna_d = sr_q[DR_W-1] ? {NCH{1'b0}} : onehot_s;
                end else if (act_ack) begin
                    state_d = ST_IDLE;
                    ta_d    = {NCH{1'b0}};
                    tna_d   = {NCH{1'b0}};
                end else if (upd_evt_q) begin
                    ovr_d = 1'b1;
                end else begin
                    state_d = ST_CMD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ta_d    = {NCH{1'b0}};
                tna_d   = {NCH{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CMD);
    end

`ifdef DBG_PARITY_EN
    // Parity error pulse and saturating error counter
    always_comb begin
        if (upd_evt_q && !good_upd_s) begin
            par_err_d = 1'b1;
            par_cnt_d = (par_cnt_q == 8'hFF) ? par_cnt_q : par_cnt_q + 8'd1;
        end else begin
            par_err_d = 1'b0;
            par_cnt_d = par_cnt_q;
        end
    end

    // Parity status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= 1'b0;
            par_cnt_q <= 8'd0;
        end else begin
            par_err_q <= par_err_d;
            par_cnt_q <= par_cnt_d;
        end
    end
`endif

    // State registers for the whole block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            tck_prev_q <= 1'b0;
            udr_prev_q <= 1'b0;
            upd_evt_q  <= 1'b0;
            upd_ir_q   <= {IR_W{1'b0}};
            sr_q       <= {DR_W{1'b0}};
            tdo_q      <= 1'b0;
            state_q    <= ST_IDLE;
            jdo_q      <= {DR_W{1'b0}};
            ta_q       <= {NCH{1'b0}};
            tna_q      <= {NCH{1'b0}};
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tck_prev_q <= tck_prev_d;
            udr_prev_q <= udr_prev_d;
            upd_evt_q  <= upd_evt_d;
            upd_ir_q   <= upd_ir_d;
            sr_q       <= sr_d;
            tdo_q      <= tdo_d;
            state_q    <= state_d;
            jdo_q      <= jdo_d;
            ta_q       <= ta_d;
            tna_q      <= tna_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

endmodule
